exe_operand_forward: RTL and testbench
======================================

# exe_operand_forward

EXE-stage operand register and forwarding datapath, directly downstream of the forwarding unit. Latches decoded operands at the ID→EXE edge and inserts bubbles on stall or flush. Applies the forwarding unit's registered `EXE_A_Select`, `EXE_B_Select` and `MEM_Data_select` codes to produce the final ALU operands and store data. Keeps one cycle of written-back history so that code 3 (producer three instructions ahead) still resolves.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register index width
- `CLK`  in  1  clock, all state updates on posedge
- `RESET`  in  1  synchronous, active-high
- `hold`  in  1  freeze EXE contents (downstream not ready)
- `flush`  in  1  kill the instruction entering EXE (taken branch/jump)
- `stall`  in  1  forwarding-unit stall; bubble into EXE
- `id_valid`, `id_reg_write`, `id_store`, `id_use_imm`  in  1 each  decoded attributes
- `id_dest`  in  REG_W  destination register
- `id_rs_data`, `id_rt_data`, `id_imm`  in  DATA_W  register-file reads; sign-extended immediate
- `a_select`, `b_select`, `mem_data_select`  in  2 each  forwarding codes, valid while the instruction is in EXE
- `mem_value`  in  DATA_W  final result of the instruction now in MEM
- `wb_value`  in  DATA_W  value being written back this cycle
- `wb_write`  in  1  `wb_value` is a real write
- `exe_valid`, `exe_reg_write`, `exe_store`  out  1 each
- `exe_dest`  out  REG_W
- `exe_op_a`, `exe_op_b`, `exe_store_data`  out  DATA_W  resolved operands (combinational from state and inputs)

## Operation
- Select codes: 0 = raw register value; 1 = `mem_value`; 2 = `wb_value`; 3 = `hist_value`.
- `exe_op_a` = mux(`a_select`, raw_rs).
- `exe_op_b` = `exe_use_imm` ? imm : mux(`b_select`, raw_rt).
- `exe_store_data` = mux(`mem_data_select`, raw_rt).
- `hist_value` register: loads `wb_value` every cycle when `wb_write`, otherwise loads 0. It is not frozen by `hold`, because the write-back stage keeps advancing.
- EXE register update priority per edge: RESET > flush > hold > stall > load.
  - RESET: all state cleared.
  - flush: bubble. valid, reg_write, store = 0; dest = 0; data fields keep their old values.
  - hold: control fields are kept. raw_rs, raw_rt and raw store-data are overwritten with the current resolved values, and a `resolved` flag is set. While `resolved`=1, all three muxes force code 0, because upstream codes have moved on. `resolved` clears on the next load, bubble or flush.
  - stall: bubble, same as flush.
  - load: all `id_*` fields captured; `resolved` = 0.
- Bubbles never assert `exe_reg_write` or `exe_store`, even when `id_valid`=1.
- Immediate bypass: when `exe_use_imm`=1, `b_select` is ignored for `exe_op_b`, but the store-data path still honours `mem_data_select`.

## Timing
- Reset values: `exe_valid`, `exe_reg_write`, `exe_store` = 0; `exe_dest` = 0; raw registers and `hist_value` = 0. The operand outputs are therefore 0 with codes 0.
- Latency: one cycle from ID inputs to EXE state.
- Operand outputs are combinational in the same cycle as the select codes and `mem_value`/`wb_value`.
- A hold of N cycles keeps outputs stable from cycle 2 onward, regardless of select-code changes.
- Releasing hold with stall=1 inserts a bubble on that edge.
- RESET during hold clears everything, including `resolved`.
- Back-to-back flushes produce consecutive bubbles.

## Structure
- Shared package `pipe_pkg` holds:
  - localparams FWD_NONE=0, FWD_MEM=1, FWD_WB=2, FWD_HIST=3
  - DATA_W and REG_W defaults
  - a struct for the EXE control bundle (valid, reg_write, store, use_imm, dest)
- One sub-module `fwd_mux4` (DATA_W-wide 4:1 select with force-zero input), instantiated three times.

## Test plan
- Reset, then ADD with codes 0, rs=5, rt=7: `exe_op_a`=5 and `exe_op_b`=7 one cycle after issue; `exe_reg_write`=1.
- `a_select`=1 with `mem_value`=0x10, `b_select`=2 with `wb_value`=0x20: operands 0x10 and 0x20 in the same cycle.
- WB writes 0x33 (`wb_write`=1), next instruction uses `a_select`=3: `exe_op_a`=0x33. Repeat with `wb_write`=0: `exe_op_a`=0.
- Store with `id_use_imm`=1, imm=4, `mem_data_select`=1, `mem_value`=0xAB: `exe_op_b`=4, `exe_store_data`=0xAB.
- `hold` for 3 cycles while `a_select` toggles and `mem_value` changes after the first cycle: `exe_op_a` stays at the first-cycle value.
- flush and stall asserted with `id_valid`=1: `exe_valid`, `exe_reg_write`, `exe_store` = 0. flush together with hold gives a bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, default widths and
// the EXE-stage control bundle.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_HIST = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 store;
    logic                 use_imm;
    logic [DEF_REG_W-1:0] dest;
  } exe_ctrl_t;

endpackage

// File: rtl/fwd_mux4.sv
// Four-way forwarding operand select. force_zero overrides the select code
// with FWD_NONE so a held instruction ignores codes that have moved on.
module fwd_mux4
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        sel,
  input  logic              force_zero,
  input  logic [DATA_W-1:0] raw_value,
  input  logic [DATA_W-1:0] mem_value,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [DATA_W-1:0] hist_value,
  output logic [DATA_W-1:0] out_value
);

  logic [1:0] eff_sel;

  // Pick the operand source named by the effective select code.
  always_comb begin
    eff_sel = force_zero ? FWD_NONE : sel;
    case (eff_sel)
      FWD_MEM:  out_value = mem_value;
      FWD_WB:   out_value = wb_value;
      FWD_HIST: out_value = hist_value;
      default:  out_value = raw_value;
    endcase
  end

endmodule

// File: rtl/exe_operand_forward.sv
// EXE-stage operand register with forwarding resolution. Captures decoded
// operands from ID, inserts bubbles on flush/stall, freezes on hold (folding
// the forwarded values into the raw registers) and keeps one cycle of
// write-back history for producers three instructions ahead.
module exe_operand_forward
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              hold,
  input  logic              flush,
  input  logic              stall,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_store,
  input  logic              id_use_imm,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        a_select,
  input  logic [1:0]        b_select,
  input  logic [1:0]        mem_data_select,
  input  logic [DATA_W-1:0] mem_value,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              wb_write,
  output logic              exe_valid,
  output logic              exe_reg_write,
  output logic              exe_store,
  output logic [REG_W-1:0]  exe_dest,
  output logic [DATA_W-1:0] exe_op_a,
  output logic [DATA_W-1:0] exe_op_b,
  output logic [DATA_W-1:0] exe_store_data
);

  // The control bundle carries dest at the package default width.
  exe_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] raw_rs_q, raw_rs_d;
  logic [DATA_W-1:0] raw_rt_q, raw_rt_d;
  logic [DATA_W-1:0] raw_sd_q, raw_sd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] hist_q, hist_d;
  logic              resolved_q, resolved_d;
  logic [DATA_W-1:0] op_b_fwd;

  fwd_mux4 #(.DATA_W(DATA_W)) u_mux_a (
    .sel        (a_select),
    .force_zero (resolved_q),
    .raw_value  (raw_rs_q),
    .mem_value  (mem_value),
    .wb_value   (wb_value),
    .hist_value (hist_q),
    .out_value  (exe_op_a)
  );

  fwd_mux4 #(.DATA_W(DATA_W)) u_mux_b (
    .sel        (b_select),
    .force_zero (resolved_q),
    .raw_value  (raw_rt_q),
    .mem_value  (mem_value),
    .wb_value   (wb_value),
    .hist_value (hist_q),
    .out_value  (op_b_fwd)
  );

  fwd_mux4 #(.DATA_W(DATA_W)) u_mux_sd (
    .sel        (mem_data_select),
    .force_zero (resolved_q),
    .raw_value  (raw_sd_q),
    .mem_value  (mem_value),
    .wb_value   (wb_value),
    .hist_value (hist_q),
    .out_value  (exe_store_data)
  );

  // Immediate bypass applies to operand B only; store data always forwards.
  assign exe_op_b      = ctrl_q.use_imm ? imm_q : op_b_fwd;
  assign exe_valid     = ctrl_q.valid;
  assign exe_reg_write = ctrl_q.reg_write;
  assign exe_store     = ctrl_q.store;
  assign exe_dest      = ctrl_q.dest;

  // Next-state: flush > hold > stall > load; history tracks write-back.
  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a value unassigned,
    // which would otherwise infer a latch.
    ctrl_d     = ctrl_q;
    raw_rs_d   = raw_rs_q;
    raw_rt_d   = raw_rt_q;
    raw_sd_d   = raw_sd_q;
    imm_d      = imm_q;
    resolved_d = resolved_q;
    hist_d     = wb_write ? wb_value : '0;

    if (flush || (!hold && stall)) begin
      // Bubble: control cleared, data left as-is.
      ctrl_d     = '0;
      resolved_d = 1'b0;
    end else if (hold) begin
      // Fold the forwarded values in so later code changes cannot disturb them.
      raw_rs_d   = exe_op_a;
      raw_rt_d   = op_b_fwd;
      raw_sd_d   = exe_store_data;
      resolved_d = 1'b1;
    end else begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_valid & id_reg_write;
      ctrl_d.store     = id_valid & id_store;
      ctrl_d.use_imm   = id_use_imm;
      ctrl_d.dest      = id_dest;
      raw_rs_d         = id_rs_data;
      raw_rt_d         = id_rt_data;
      raw_sd_d         = id_rt_data;
      imm_d            = id_imm;
      resolved_d       = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      ctrl_q     <= '0;
      raw_rs_q   <= '0;
      raw_rt_q   <= '0;
      raw_sd_q   <= '0;
      imm_q      <= '0;
      hist_q     <= '0;
      resolved_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      raw_rs_q   <= raw_rs_d;
      raw_rt_q   <= raw_rt_d;
      raw_sd_q   <= raw_sd_d;
      imm_q      <= imm_d;
      hist_q     <= hist_d;
      resolved_q <= resolved_d;
    end
  end

endmodule

// File: tb/tb_exe_operand_forward.sv
// Self-checking bench for exe_operand_forward. Expected EXE observations are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_exe_operand_forward;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        st;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        hold, flush, stall;
  logic        id_valid, id_reg_write, id_store, id_use_imm;
  logic [4:0]  id_dest;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [1:0]  a_select, b_select, mem_data_select;
  logic [31:0] mem_value, wb_value;
  logic        wb_write;
  logic        exe_valid, exe_reg_write, exe_store;
  logic [4:0]  exe_dest;
  logic [31:0] exe_op_a, exe_op_b, exe_store_data;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t got, exp;

  exe_operand_forward dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .hold            (hold),
    .flush           (flush),
    .stall           (stall),
    .id_valid        (id_valid),
    .id_reg_write    (id_reg_write),
    .id_store        (id_store),
    .id_use_imm      (id_use_imm),
    .id_dest         (id_dest),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .a_select        (a_select),
    .b_select        (b_select),
    .mem_data_select (mem_data_select),
    .mem_value       (mem_value),
    .wb_value        (wb_value),
    .wb_write        (wb_write),
    .exe_valid       (exe_valid),
    .exe_reg_write   (exe_reg_write),
    .exe_store       (exe_store),
    .exe_dest        (exe_dest),
    .exe_op_a        (exe_op_a),
    .exe_op_b        (exe_op_b),
    .exe_store_data  (exe_store_data)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    return '{exe_valid, exe_reg_write, exe_store, exe_dest,
             exe_op_a, exe_op_b, exe_store_data};
  endfunction

  function automatic obs_t mk(logic v, logic rw, logic st, logic [4:0] d,
                              logic [31:0] a, logic [31:0] b, logic [31:0] sd);
    return '{v, rw, st, d, a, b, sd};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(logic v, logic rw, logic st, logic ui, logic [4:0] d,
                       logic [31:0] rs, logic [31:0] rt, logic [31:0] imm);
    id_valid = v; id_reg_write = rw; id_store = st; id_use_imm = ui;
    id_dest = d; id_rs_data = rs; id_rt_data = rt; id_imm = imm;
  endtask

  task automatic codes(logic [1:0] a, logic [1:0] b, logic [1:0] s);
    a_select = a; b_select = b; mem_data_select = s;
  endtask

  task automatic test_reset();
    RESET = 1'b1; hold = 0; flush = 0; stall = 0; wb_write = 0;
    mem_value = 32'h0; wb_value = 32'h0;
    issue(1, 1, 1, 0, 5'd9, 32'hDEAD, 32'hBEEF, 32'h1);
    codes(0, 0, 0);
    tick(); tick();
    RESET = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_add();
    issue(1, 1, 0, 0, 5'd3, 32'd5, 32'd7, 32'd0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    codes(0, 0, 0);
    exp_q.push_back(mk(1, 1, 0, 5'd3, 32'd5, 32'd7, 32'd7));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL add_raw got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_fwd_mem_wb();
    issue(1, 1, 0, 0, 5'd4, 32'd1, 32'd2, 32'd0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    codes(1, 2, 0);
    mem_value = 32'h10; wb_value = 32'h20;
    exp_q.push_back(mk(1, 1, 0, 5'd4, 32'h10, 32'h20, 32'd2));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL fwd_mem_wb got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_hist();
    codes(0, 0, 0);
    wb_value = 32'h33; wb_write = 1'b1;
    issue(1, 1, 0, 0, 5'd6, 32'h9, 32'h8, 32'd0);
    tick();
    wb_write = 1'b0; wb_value = 32'h44;
    codes(3, 0, 0);
    exp_q.push_back(mk(1, 1, 0, 5'd6, 32'h33, 32'h8, 32'h8));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hist_write got=%h exp=%h", got, exp);
    end
    // wb_write is low across this edge, so history becomes zero.
    issue(1, 1, 0, 0, 5'd7, 32'h9, 32'h8, 32'd0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    codes(3, 0, 0);
    exp_q.push_back(mk(1, 1, 0, 5'd7, 32'h0, 32'h8, 32'h8));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hist_nowrite got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_store_imm();
    codes(0, 0, 0);
    issue(1, 0, 1, 1, 5'd0, 32'h100, 32'h55, 32'd4);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    codes(0, 2, 1);
    mem_value = 32'hAB; wb_value = 32'h99;
    exp_q.push_back(mk(1, 0, 1, 5'd0, 32'h100, 32'd4, 32'hAB));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL store_imm got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_hold();
    codes(0, 0, 0);
    issue(1, 1, 0, 0, 5'd5, 32'h11, 32'h22, 32'd0);
    tick();
    // Cycle 1 of hold: forwarded value from MEM.
    hold = 1'b1;
    issue(1, 1, 1, 0, 5'd12, 32'hAAAA, 32'hBBBB, 32'd0);
    codes(1, 0, 0); mem_value = 32'h50;
    exp_q.push_back(mk(1, 1, 0, 5'd5, 32'h50, 32'h22, 32'h22));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hold_c1 got=%h exp=%h", got, exp);
    end
    // Cycles 2 and 3: codes and MEM value change, outputs must not.
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) begin codes(0, 0, 0); mem_value = 32'h60; end
      else begin codes(1, 1, 1); mem_value = 32'h70; end
      exp_q.push_back(mk(1, 1, 0, 5'd5, 32'h50, 32'h22, 32'h22));
      @(negedge CLK);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_c%0d got=%h exp=%h", i + 2, got, exp);
      end
    end
    // Release hold with stall high: still stable this cycle, bubble next.
    tick();
    hold = 1'b0; stall = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 5'd5, 32'h50, 32'h22, 32'h22));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hold_release got=%h exp=%h", got, exp);
    end
    tick();
    stall = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    codes(0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'h50, 32'h22, 32'h22));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL hold_stall_bubble got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_flush_stall();
    codes(0, 0, 0);
    issue(1, 1, 1, 0, 5'd8, 32'hA, 32'hB, 32'd0);
    tick();
    // Two back-to-back flushes, then a stall, all with valid ID inputs.
    exp_q.push_back(mk(1, 1, 1, 5'd8, 32'hA, 32'hB, 32'hB));
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'hA, 32'hB, 32'hB));
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'hA, 32'hB, 32'hB));
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'hA, 32'hB, 32'hB));
    for (int i = 0; i < 4; i++) begin
      flush = (i == 0 || i == 1);
      stall = (i == 2);
      issue(1, 1, 1, 0, 5'(20 + i), 32'hC0 + 32'(i), 32'hD0, 32'd0);
      @(negedge CLK);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL flush_stall_%0d got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    // Flush wins over hold.
    flush = 1'b0; stall = 1'b0;
    issue(1, 1, 0, 0, 5'd9, 32'hE, 32'hF, 32'd0);
    tick();
    hold = 1'b1; flush = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 1, 0, 5'd9, 32'hE, 32'hF, 32'hF));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL flush_hold_pre got=%h exp=%h", got, exp);
    end
    tick();
    flush = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'hE, 32'hF, 32'hF));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL flush_hold_bubble got=%h exp=%h", got, exp);
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    codes(0, 0, 0);
    issue(1, 1, 0, 0, 5'd2, 32'h77, 32'h66, 32'd0);
    tick();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    hold = 1'b1; codes(1, 1, 1); mem_value = 32'h5;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mem_value = 32'h66;
    // resolved must be clear, so code 1 forwards the new MEM value.
    exp_q.push_back(mk(0, 0, 0, 5'd0, 32'h66, 32'h66, 32'h66));
    @(negedge CLK);
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_in_hold got=%h exp=%h", got, exp);
    end
    hold = 1'b0;
    codes(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    codes(0, 0, 0);
    issue(1, 1, 0, 0, 5'd10, 32'h123, 32'h456, 32'd0);
    exp_q.push_back(mk(1, 1, 0, 5'd10, 32'h123, 32'h456, 32'h456));
    tick();
    issue(1, 0, 1, 1, 5'd11, 32'h789, 32'hABC, 32'hFFFF_FFF0);
    exp_q.push_back(mk(1, 0, 1, 5'd11, 32'h789, 32'hFFFF_FFF0, 32'hABC));
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%h exp=%h", i, got, exp);
      end
      tick();
      issue(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fwd_mem_wb();
    test_hist();
    test_store_imm();
    test_hold();
    test_flush_stall();
    test_reset_in_hold();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
